// File: rtl/rps_pkg.sv
// Shared choice/mode encodings and sequencer state type for the
// rock-paper-scissors round front-end.
package rps_pkg;

    localparam logic [1:0] ROCK    = 2'b00;
    localparam logic [1:0] SCISSOR = 2'b01;
    localparam logic [1:0] PAPER   = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    localparam logic [1:0] MODE_RANDOM    = 2'b00;
    localparam logic [1:0] MODE_MARKOV    = 2'b01;
    localparam logic [1:0] MODE_REINFORCE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS      = 3'd1,
        S_WAIT_READY = 3'd2,
        S_COMMIT     = 3'd3,
        S_DRAW_REQ   = 3'd4,
        S_DRAW_WAIT  = 3'd5,
        S_RELEASE    = 3'd6
    } seq_state_e;

endpackage

// File: rtl/key_debouncer.sv
// Start-key synchronizer plus saturating stable-sample counter; the caller
// picks which key level is being qualified and when the count restarts.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    input  logic clear,
    input  logic level,
    output logic key_s,
    output logic stable_done
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchronizer; idles at the released (high) level.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_n};
        end
    end

    assign key_s = sync_r[1];

    // Counts consecutive samples at the qualified level, saturating at the target.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clear || (key_s != level)) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign stable_done = (cnt_r == CNT_MAX) && (key_s == level);

endmodule

// File: rtl/rps_round_sequencer.sv
// One-round sequencer: debounced start key, choice snapshot, optional wait on
// the reinforce player, then a commit strobe and a single drawer request.
module rps_round_sequencer
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_n,
    input  logic [1:0] user_sw,
    input  logic [1:0] mode,
    input  logic [1:0] com_ra,
    input  logic [1:0] com_m,
    input  logic [1:0] com_re,
    input  logic       re_ready,
    input  logic       draw_busy,
    output logic       round_go,
    output logic [1:0] user_q,
    output logic [1:0] com_q,
    output logic       draw_start,
    output logic       reject,
    output logic       busy
);

    seq_state_e state_r, state_s;
    logic [1:0] user_l_r, mode_l_r;
    logic       draw_first_r;
    logic       key_s, stable_done_s;
    logic       clear_s, level_s, accept_s;
    logic [1:0] com_sel_s;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debouncer (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_n       (key_n),
        .clear       (clear_s),
        .level       (level_s),
        .key_s       (key_s),
        .stable_done (stable_done_s)
    );

    // Next-state logic; the counter restarts on every state change.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!key_s) state_s = S_PRESS;
                else        state_s = S_IDLE;
            end
            S_PRESS: begin
                if (key_s) begin
                    state_s = S_IDLE;
                end else if (stable_done_s) begin
                    accept_s = 1'b1;
                    if (user_sw == INVALID)                          state_s = S_RELEASE;
                    else if ((mode == MODE_REINFORCE) && !re_ready)  state_s = S_WAIT_READY;
                    else                                             state_s = S_COMMIT;
                end else begin
                    state_s = S_PRESS;
                end
            end
            S_WAIT_READY: begin
                if (re_ready) state_s = S_COMMIT;
                else          state_s = S_WAIT_READY;
            end
            S_COMMIT:   state_s = S_DRAW_REQ;
            S_DRAW_REQ: state_s = S_DRAW_WAIT;
            S_DRAW_WAIT: begin
                if (!draw_first_r && !draw_busy) state_s = S_RELEASE;
                else                             state_s = S_DRAW_WAIT;
            end
            S_RELEASE: begin
                if (stable_done_s) state_s = S_IDLE;
                else               state_s = S_RELEASE;
            end
            default: state_s = S_IDLE;
        endcase
        clear_s = (state_s != state_r) || !((state_r == S_PRESS) || (state_r == S_RELEASE));
        level_s = (state_r == S_RELEASE);
    end

    // Opponent selection from the mode latched at acceptance; 11 falls back to random.
    always_comb begin
        com_sel_s = com_ra;
        case (mode_l_r)
            MODE_MARKOV:    com_sel_s = com_m;
            MODE_REINFORCE: com_sel_s = com_re;
            default:        com_sel_s = com_ra;
        endcase
    end

    // State, snapshot and registered strobe outputs.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            user_l_r     <= ROCK;
            mode_l_r     <= MODE_RANDOM;
            draw_first_r <= 1'b0;
            round_go     <= 1'b0;
            draw_start   <= 1'b0;
            reject       <= 1'b0;
            busy         <= 1'b0;
            user_q       <= 2'b00;
            com_q        <= 2'b00;
        end else begin
            state_r      <= state_s;
            draw_first_r <= (state_s == S_DRAW_WAIT) && (state_r != S_DRAW_WAIT);
            round_go     <= (state_s == S_COMMIT);
            draw_start   <= (state_s == S_DRAW_REQ);
            reject       <= accept_s && (user_sw == INVALID);
            busy         <= (state_s != S_IDLE);
            if (accept_s) begin
                user_l_r <= user_sw;
                mode_l_r <= mode;
            end
            if (state_r == S_COMMIT) begin
                user_q <= user_l_r;
                com_q  <= com_sel_s;
            end
        end
    end

endmodule
